// File: rtl/fpu_tag_pipe_if.sv
// fpu_tag_pipe_if: issue handshake and tag/writeback outputs of the FP tag pipeline
interface fpu_tag_pipe_if #(
    parameter int TAG_W = 5
);
    logic             issue_valid;
    logic [TAG_W-1:0] issue_fd;
    logic             issue_kind;
    logic             stallD;
    logic             issue_ready;
    logic [TAG_W-1:0] Cfd;
    logic [TAG_W-1:0] Afd;
    logic [TAG_W-1:0] Ofd;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_fd;
    logic [2:0]       occupancy;

    modport master (
        output issue_valid, issue_fd, issue_kind, stallD,
        input  issue_ready, Cfd, Afd, Ofd, wb_valid, wb_fd, occupancy
    );

    modport slave (
        input  issue_valid, issue_fd, issue_kind, stallD,
        output issue_ready, Cfd, Afd, Ofd, wb_valid, wb_fd, occupancy
    );
endinterface

// File: rtl/fpu_tag_pipe.sv
// fpu_tag_pipe: tracks FP destination tags through stages C, A, O (multi-cycle MUL) and W
module fpu_tag_pipe #(
    parameter int MUL_LAT = 4,
    parameter int TAG_W   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    fpu_tag_pipe_if.slave bus
);
    localparam int CW = $clog2(MUL_LAT);
    localparam logic [CW-1:0] CNT_MAX = CW'(MUL_LAT - 1);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] fd;
        logic             kind;
    } stage_t;

    stage_t           c_q, c_d, a_q, a_d, o_q, o_d;
    logic             w_vld_q, w_vld_d;
    logic [TAG_W-1:0] w_fd_q, w_fd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             o_done, o_accept, a_accept, c_accept, fire;

    // Backward-propagating accept chain: a stage may load when empty or when its occupant moves on
    always_comb begin
        o_done   = o_q.vld & (~o_q.kind | (cnt_q == CNT_MAX));
        o_accept = ~o_q.vld | o_done;
        a_accept = ~a_q.vld | o_accept;
        c_accept = ~c_q.vld | a_accept;
        fire     = bus.issue_valid & ~bus.stallD & c_accept;
    end

    // Next state: shift entries forward in order; C takes a bubble when it advances without a new issue
    always_comb begin
        c_d     = c_q;
        a_d     = a_q;
        o_d     = o_q;
        cnt_d   = cnt_q;
        w_vld_d = o_done;
        w_fd_d  = o_done ? o_q.fd : '0;
        if (fire) begin
            c_d.vld  = 1'b1;
            c_d.fd   = bus.issue_fd;
            c_d.kind = bus.issue_kind;
        end else if (a_accept) begin
            c_d = '0;
        end
        if (a_accept)
            a_d = c_q;
        if (o_accept) begin
            o_d   = a_q;
            cnt_d = '0;
        end else if (o_q.vld && o_q.kind && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Pipeline registers; asynchronous reset discards every in-flight entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q     <= '0;
            a_q     <= '0;
            o_q     <= '0;
            cnt_q   <= '0;
            w_vld_q <= 1'b0;
            w_fd_q  <= '0;
        end else begin
            c_q     <= c_d;
            a_q     <= a_d;
            o_q     <= o_d;
            cnt_q   <= cnt_d;
            w_vld_q <= w_vld_d;
            w_fd_q  <= w_fd_d;
        end
    end

    // Tags are gated by valid so an empty stage reports no dependency
    assign bus.issue_ready = c_accept;
    assign bus.Cfd         = c_q.vld ? c_q.fd : '0;
    assign bus.Afd         = a_q.vld ? a_q.fd : '0;
    assign bus.Ofd         = o_q.vld ? o_q.fd : '0;
    assign bus.wb_valid    = w_vld_q;
    assign bus.wb_fd       = w_vld_q ? w_fd_q : '0;
    assign bus.occupancy   = {2'b00, c_q.vld} + {2'b00, a_q.vld} + {2'b00, o_q.vld} + {2'b00, w_vld_q};
endmodule

// File: tb/tb_fpu_tag_pipe.sv
// tb_fpu_tag_pipe: directed stimulus with a writeback scoreboard for fpu_tag_pipe
module tb_fpu_tag_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   sb[$];
    int   occ_max;
    logic ready_seen_low;

    fpu_tag_pipe_if #(.TAG_W(5)) bus ();

    fpu_tag_pipe #(.MUL_LAT(4), .TAG_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int fd, input logic kind);
        bus.issue_valid = v;
        bus.issue_fd    = 5'(fd);
        bus.issue_kind  = kind;
        if (v) sb.push_back(fd);
    endtask

    task automatic check_idle(input string name);
        check({name, "_Cfd"}, 32'(bus.Cfd), 0);
        check({name, "_Afd"}, 32'(bus.Afd), 0);
        check({name, "_Ofd"}, 32'(bus.Ofd), 0);
        check({name, "_wb_valid"}, 32'(bus.wb_valid), 0);
        check({name, "_occ"}, 32'(bus.occupancy), 0);
        check({name, "_ready"}, 32'(bus.issue_ready), 1);
    endtask

    // Writeback scoreboard: every writeback must match the oldest issued tag
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.wb_valid === 1'b1) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL wb_unexpected: observed %0d expected none", bus.wb_fd);
            end
            if (sb.size() != 0) check("wb_order", 32'(bus.wb_fd), 32'(sb.pop_front()));
        end
    end

    initial begin
        bus.issue_valid = 1'b0;
        bus.issue_fd    = '0;
        bus.issue_kind  = 1'b0;
        bus.stallD      = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_idle("reset");
        step();
        rst_n = 1'b1;

        // Single ADD
        drive(1, 7, 0);
        step(); check("add_C", 32'(bus.Cfd), 7); drive(0, 0, 0);
        step(); check("add_A", 32'(bus.Afd), 7);
        step(); check("add_O", 32'(bus.Ofd), 7);
        step(); check("add_wb_valid", 32'(bus.wb_valid), 1); check("add_wb_fd", 32'(bus.wb_fd), 7);
        step(); check_idle("add_after");

        // MUL backpressure
        drive(1, 3, 1);
        step(); check("mul_C", 32'(bus.Cfd), 3); drive(1, 4, 0);
        step(); drive(1, 5, 0);
        step(); drive(1, 6, 0);
        check("mul_O_c3", 32'(bus.Ofd), 3); check("mul_ready_c3", 32'(bus.issue_ready), 0);
        step(); check("mul_O_c4", 32'(bus.Ofd), 3); check("mul_ready_c4", 32'(bus.issue_ready), 0);
        step(); check("mul_O_c5", 32'(bus.Ofd), 3); check("mul_ready_c5", 32'(bus.issue_ready), 0);
        step(); check("mul_O_c6", 32'(bus.Ofd), 3); check("mul_ready_c6", 32'(bus.issue_ready), 1);
        check("mul_C_c6", 32'(bus.Cfd), 5);
        step(); check("mul_wb_c7", 32'(bus.wb_fd), 3); check("mul_C_c7", 32'(bus.Cfd), 6);
        check("mul_O_c7", 32'(bus.Ofd), 4);
        drive(0, 0, 0);
        repeat (4) step();
        check_idle("mul_after");

        // stallD gating
        bus.stallD = 1'b1;
        drive(1, 9, 0);
        for (int i = 0; i < 3; i++) begin
            step(); check("stall_C", 32'(bus.Cfd), 0);
        end
        bus.stallD = 1'b0;
        step(); check("stall_C_release", 32'(bus.Cfd), 9); drive(0, 0, 0);
        repeat (5) step();
        check_idle("stall_after");

        // f0 tag
        drive(1, 0, 0);
        step(); check("f0_C", 32'(bus.Cfd), 0); check("f0_occ1", 32'(bus.occupancy), 1); drive(0, 0, 0);
        step(); check("f0_A", 32'(bus.Afd), 0); check("f0_occ2", 32'(bus.occupancy), 1);
        step(); check("f0_O", 32'(bus.Ofd), 0); check("f0_occ3", 32'(bus.occupancy), 1);
        step(); check("f0_wb_valid", 32'(bus.wb_valid), 1); check("f0_wb_fd", 32'(bus.wb_fd), 0);
        step(); check("f0_occ_after", 32'(bus.occupancy), 0);

        // Back-to-back ADDs
        occ_max = 0;
        ready_seen_low = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (bus.issue_ready !== 1'b1) ready_seen_low = 1'b1;
            if (int'(bus.occupancy) > occ_max) occ_max = int'(bus.occupancy);
            if (i == 5) check("b2b_wb_c4", 32'(bus.wb_fd), 1);
            drive(1, i, 0);
            step();
        end
        drive(0, 0, 0);
        check("b2b_ready_never_low", 32'(ready_seen_low), 0);
        check("b2b_occ_max", 32'(occ_max), 4);
        repeat (3) step();
        check("b2b_wb_c11", 32'(bus.wb_fd), 8);
        step(); check_idle("b2b_after");

        // Asynchronous reset with MUL in O and C, A full
        drive(1, 10, 1);
        step(); drive(1, 11, 0);
        step(); drive(1, 12, 0);
        step(); drive(0, 0, 0);
        check("rst_pre_O", 32'(bus.Ofd), 10);
        check("rst_pre_occ", 32'(bus.occupancy), 3);
        step();
        #2 rst_n = 1'b0;
        #1 check_idle("async_reset");
        sb.delete();
        step();
        rst_n = 1'b1;
        repeat (8) step();
        check_idle("reset_after");

        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
